// File: rtl/led_mem_writer_if.sv
// ============================================================================
// Module : led_mem_if
// Single-port block-RAM bus (ena/wea/addra/dina/douta) between the pattern
// writer (master) and the LED pattern RAM (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_mem_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              mem_ena;
    logic              mem_wea;
    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina;
    logic [DATA_W-1:0] mem_douta;

    modport master (
        output mem_ena,
        output mem_wea,
        output mem_addra,
        output mem_dina,
        input  mem_douta
    );

    modport slave (
        input  mem_ena,
        input  mem_wea,
        input  mem_addra,
        input  mem_dina,
        output mem_douta
    );
endinterface

`default_nettype wire

// File: rtl/led_mem_writer.sv
// ============================================================================
// Module : led_mem_writer
// Fills the LED pattern RAM with a generated pattern on start, then optionally
// reads every word back and flags the first address that does not match.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_mem_writer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1,
    parameter int VERIFY = 1
) (
    input  wire logic              clk_g,
    input  wire logic              rst_n,
    input  wire logic              start_i,
    input  wire logic [1:0]        mode_i,
    input  wire logic [DATA_W-1:0] fill_data_i,
    led_mem_if.master              mem,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [ADDR_W-1:0]      err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              ena_q, ena_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] dina_q, dina_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [1:0]        drain_q, drain_d;

    // Read-compare pipeline: one slot per cycle of RAM read latency
    logic              pvld_q  [RD_LAT];
    logic              pvld_d  [RD_LAT];
    logic [ADDR_W-1:0] paddr_q [RD_LAT];
    logic [ADDR_W-1:0] paddr_d [RD_LAT];
    logic [DATA_W-1:0] pexp_q  [RD_LAT];
    logic [DATA_W-1:0] pexp_d  [RD_LAT];

    logic w_mismatch;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] f,
        input logic [ADDR_W-1:0] i
    );
        logic [DATA_W-1:0] walk;
        // Shifting past DATA_W yields 0, so the thermometer saturates at all ones
        walk = {{(DATA_W-1){1'b0}}, 1'b1} << i;
        case (m)
            2'd1:    pattern = walk;
            2'd2:    pattern = f;
            default: pattern = walk - 1'b1;
        endcase
    endfunction

    assign w_mismatch = ((state_q == S_READ) || (state_q == S_DRAIN))
                        && pvld_q[RD_LAT-1]
                        && (mem.mem_douta != pexp_q[RD_LAT-1]);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        fill_d     = fill_q;
        ena_d      = 1'b0;
        wea_d      = 1'b0;
        addra_d    = '0;
        dina_d     = '0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        drain_d    = '0;
        pvld_d[0]  = 1'b0;
        paddr_d[0] = '0;
        pexp_d[0]  = '0;
        for (int k = 1; k < RD_LAT; k++) begin
            pvld_d[k]  = pvld_q[k-1];
            paddr_d[k] = paddr_q[k-1];
            pexp_d[k]  = pexp_q[k-1];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_WRITE;
                    mode_d     = mode_i;
                    fill_d     = fill_data_i;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    busy_d     = 1'b1;
                    ena_d      = 1'b1;
                    wea_d      = 1'b1;
                    dina_d     = pattern(mode_i, fill_data_i, '0);
                end
            end
            S_WRITE: begin
                if (addra_q != '1) begin
                    ena_d   = 1'b1;
                    wea_d   = 1'b1;
                    addra_d = addra_q + 1'b1;
                    dina_d  = pattern(mode_q, fill_q, addra_q + 1'b1);
                end else if (VERIFY != 0) begin
                    state_d = S_READ;
                    ena_d   = 1'b1;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_READ: begin
                pvld_d[0]  = 1'b1;
                paddr_d[0] = addra_q;
                pexp_d[0]  = pattern(mode_q, fill_q, addra_q);
                if (addra_q != '1) begin
                    ena_d   = 1'b1;
                    addra_d = addra_q + 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // First mismatch aborts: stop issuing, drop in-flight reads, finish
        if (w_mismatch) begin
            state_d    = S_DONE;
            err_d      = 1'b1;
            err_addr_d = paddr_q[RD_LAT-1];
            busy_d     = 1'b0;
            done_d     = 1'b1;
            ena_d      = 1'b0;
            wea_d      = 1'b0;
            addra_d    = '0;
            dina_d     = '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pvld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            fill_q     <= '0;
            ena_q      <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            drain_q    <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pvld_q[k]  <= 1'b0;
                paddr_q[k] <= '0;
                pexp_q[k]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            fill_q     <= fill_d;
            ena_q      <= ena_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            drain_q    <= drain_d;
            for (int k = 0; k < RD_LAT; k++) begin
                pvld_q[k]  <= pvld_d[k];
                paddr_q[k] <= paddr_d[k];
                pexp_q[k]  <= pexp_d[k];
            end
        end
    end

    assign mem.mem_ena   = ena_q;
    assign mem.mem_wea   = wea_q;
    assign mem.mem_addra = addra_q;
    assign mem.mem_dina  = dina_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_addr_o    = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_led_mem_writer.sv
// ============================================================================
// Module : tb_led_mem_writer
// Scoreboard bench for led_mem_writer: three parameter variants share stimulus,
// each driving its own behavioural RAM.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_mem_writer;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk_g = 1'b0;
    logic          rst_n;
    logic          start_v;
    logic          start_w;
    logic [1:0]    mode;
    logic [DW-1:0] fill;
    bit            fault_en;

    always #5 clk_g = ~clk_g;

    led_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    led_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    led_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    logic [2:0]    busy_a, done_a, err_a, ena_a, wea_a;
    logic [AW-1:0] eaddr_a [3];
    logic [AW-1:0] addr_a  [3];
    logic [DW-1:0] dina_a  [3];

    led_mem_writer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .VERIFY(1)) dut0 (
        .clk_g(clk_g), .rst_n(rst_n), .start_i(start_v), .mode_i(mode),
        .fill_data_i(fill), .mem(bus0), .busy_o(busy_a[0]), .done_o(done_a[0]),
        .err_o(err_a[0]), .err_addr_o(eaddr_a[0]));
    led_mem_writer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .VERIFY(1)) dut1 (
        .clk_g(clk_g), .rst_n(rst_n), .start_i(start_v), .mode_i(mode),
        .fill_data_i(fill), .mem(bus1), .busy_o(busy_a[1]), .done_o(done_a[1]),
        .err_o(err_a[1]), .err_addr_o(eaddr_a[1]));
    led_mem_writer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .VERIFY(0)) dut2 (
        .clk_g(clk_g), .rst_n(rst_n), .start_i(start_w), .mode_i(mode),
        .fill_data_i(fill), .mem(bus2), .busy_o(busy_a[2]), .done_o(done_a[2]),
        .err_o(err_a[2]), .err_addr_o(eaddr_a[2]));

    assign ena_a  = {bus2.mem_ena, bus1.mem_ena, bus0.mem_ena};
    assign wea_a  = {bus2.mem_wea, bus1.mem_wea, bus0.mem_wea};
    assign addr_a[0] = bus0.mem_addra;
    assign addr_a[1] = bus1.mem_addra;
    assign addr_a[2] = bus2.mem_addra;
    assign dina_a[0] = bus0.mem_dina;
    assign dina_a[1] = bus1.mem_dina;
    assign dina_a[2] = bus2.mem_dina;

    // Behavioural RAMs: latency 1 (optional bit-0 fault at address 7), latency 2, write-only
    logic [DW-1:0] ram0 [16];
    logic [DW-1:0] ram1 [16];
    logic [DW-1:0] ram2 [16];
    logic [DW-1:0] rd1_stage;

    always @(posedge clk_g) begin
        if (bus0.mem_ena && bus0.mem_wea) ram0[bus0.mem_addra] <= bus0.mem_dina;
        if (bus0.mem_ena && !bus0.mem_wea)
            bus0.mem_douta <= ram0[bus0.mem_addra]
                              ^ ((fault_en && bus0.mem_addra == 4'd7) ? 16'h0001 : 16'h0000);
    end
    always @(posedge clk_g) begin
        if (bus1.mem_ena && bus1.mem_wea) ram1[bus1.mem_addra] <= bus1.mem_dina;
        if (bus1.mem_ena && !bus1.mem_wea) rd1_stage <= ram1[bus1.mem_addra];
        bus1.mem_douta <= rd1_stage;
    end
    always @(posedge clk_g) begin
        if (bus2.mem_ena && bus2.mem_wea) ram2[bus2.mem_addra] <= bus2.mem_dina;
    end
    assign bus2.mem_douta = '0;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct packed { int lat; logic err; logic [AW-1:0] ea; int reads; int writes; } res_t;

    wr_t  wq  [$];
    res_t rq0 [$];
    res_t rq1 [$];
    res_t rq2 [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk_g) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [1:0] m, input logic [DW-1:0] f, input int i);
        logic [DW-1:0] one;
        one = 16'h0001;
        case (m)
            2'd1:    return one << i;
            2'd2:    return f;
            default: return (one << i) - 16'h0001;
        endcase
    endfunction

    // Monitor: pops expected writes and end-of-sequence results as the DUTs present them
    initial begin : monitor
        logic [2:0] busy_p;
        logic [2:0] done_p;
        int t0 [3];
        int nrd [3];
        int nwr [3];
        wr_t w;
        res_t r;
        bit have;
        busy_p = '0;
        done_p = '0;
        forever begin
            @(negedge clk_g);
            for (int d = 0; d < 3; d++) begin
                if (busy_a[d] && !busy_p[d]) begin
                    t0[d] = cyc - 1; nrd[d] = 0; nwr[d] = 0;
                end
                if (ena_a[d] && wea_a[d])  nwr[d]++;
                if (ena_a[d] && !wea_a[d]) nrd[d]++;
            end
            if (ena_a[0] && wea_a[0]) begin
                if (wq.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = wq.pop_front();
                    for (int d = 0; d < 3; d++) begin
                        chk($sformatf("wr_addr[%0d]", d), int'(addr_a[d]), int'(w.a));
                        chk($sformatf("wr_data[%0d]", d), int'(dina_a[d]), int'(w.d));
                        chk($sformatf("wr_en[%0d]", d), int'(ena_a[d] && wea_a[d]), 1);
                    end
                end
            end
            for (int d = 0; d < 3; d++) begin
                if (done_a[d] && !done_p[d]) begin
                    have = 1'b0;
                    case (d)
                        0: if (rq0.size() > 0) begin r = rq0.pop_front(); have = 1'b1; end
                        1: if (rq1.size() > 0) begin r = rq1.pop_front(); have = 1'b1; end
                        default: if (rq2.size() > 0) begin r = rq2.pop_front(); have = 1'b1; end
                    endcase
                    if (!have) chk($sformatf("unexpected_done[%0d]", d), 1, 0);
                    else begin
                        chk($sformatf("done_cycle[%0d]", d), cyc - t0[d], r.lat);
                        chk($sformatf("err[%0d]", d), int'(err_a[d]), int'(r.err));
                        chk($sformatf("err_addr[%0d]", d), int'(eaddr_a[d]), int'(r.ea));
                        chk($sformatf("reads[%0d]", d), nrd[d], r.reads);
                        chk($sformatf("writes[%0d]", d), nwr[d], r.writes);
                        chk($sformatf("busy_at_done[%0d]", d), int'(busy_a[d]), 0);
                    end
                end
            end
            busy_p = busy_a;
            done_p = done_a;
        end
    end

    task automatic push_writes(input logic [1:0] m, input logic [DW-1:0] f);
        wr_t w;
        for (int i = 0; i < 16; i++) begin
            w.a = AW'(i);
            w.d = pat(m, f, i);
            wq.push_back(w);
        end
    endtask

    task automatic push_all(input logic [1:0] m, input logic [DW-1:0] f, input bit flt);
        res_t r;
        push_writes(m, f);
        r.err = flt; r.ea = flt ? 4'd7 : 4'd0; r.lat = flt ? 26 : 34;
        r.reads = flt ? 9 : 16; r.writes = 16;
        rq0.push_back(r);
        r.err = 1'b0; r.ea = 4'd0; r.lat = 35; r.reads = 16;
        rq1.push_back(r);
        r.lat = 17; r.reads = 0;
        rq2.push_back(r);
    endtask

    // Start on edge 0; inputs change right after so only the latched values matter
    task automatic launch(input logic [1:0] m, input logic [DW-1:0] f);
        @(negedge clk_g);
        mode = m; fill = f; start_v = 1'b1; start_w = 1'b1;
        @(negedge clk_g);
        start_v = 1'b0; start_w = 1'b0;
        mode = m + 2'd1; fill = ~f;
        chk("cyc1_done_clr", int'(done_a[0]), 0);
        chk("cyc1_err_clr", int'(err_a[0]), 0);
        chk("cyc1_busy", int'(busy_a), 7);
    endtask

    task automatic run_seq(input logic [1:0] m, input logic [DW-1:0] f, input int p_any, input int p_rd);
        bit fin;
        launch(m, f);
        fin = 1'b0;
        for (int n = 2; n <= 80 && !fin; n++) begin
            @(negedge clk_g);
            start_v = (n == p_any) || (n == p_rd);
            start_w = (n == p_any);
            if (done_a == 3'b111 && busy_a == 3'b000) fin = 1'b1;
        end
        start_v = 1'b0; start_w = 1'b0;
        chk("seq_complete", int'(fin), 1);
    endtask

    task automatic chk_ram(input logic [1:0] m, input logic [DW-1:0] f);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ram0[%0d]", i), int'(ram0[i]), int'(pat(m, f, i)));
            chk($sformatf("ram2[%0d]", i), int'(ram2[i]), int'(pat(m, f, i)));
        end
    endtask

    initial begin : stim
        rst_n = 1'b0; start_v = 1'b0; start_w = 1'b0;
        mode = 2'd0; fill = '0; fault_en = 1'b0;
        repeat (3) @(negedge clk_g);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_err_addr", int'(eaddr_a[0]), 0);
        chk("rst_ena", int'(ena_a), 0);
        chk("rst_wea", int'(wea_a), 0);
        chk("rst_addr", int'(addr_a[0]), 0);
        chk("rst_dina", int'(dina_a[0]), 0);
        rst_n = 1'b1;
        @(negedge clk_g);

        push_all(2'd0, 16'h0000, 1'b0);
        run_seq(2'd0, 16'h0000, 0, 0);
        chk_ram(2'd0, 16'h0000);
        chk("thermo_top", int'(ram0[15]), 32'h7FFF);
        chk("thermo_bottom", int'(ram0[0]), 0);

        push_all(2'd1, 16'h0000, 1'b0);
        run_seq(2'd1, 16'h0000, 0, 0);
        chk_ram(2'd1, 16'h0000);
        chk("walk_top", int'(ram1[15]), 32'h8000);
        chk("walk_first", int'(ram1[0]), 1);

        push_all(2'd2, 16'hA5A5, 1'b0);
        run_seq(2'd2, 16'hA5A5, 0, 0);
        chk_ram(2'd2, 16'hA5A5);

        push_all(2'd3, 16'hFFFF, 1'b0);
        run_seq(2'd3, 16'hFFFF, 0, 0);
        chk("mode3_entry3", int'(ram0[3]), 32'h0007);

        fault_en = 1'b1;
        push_all(2'd0, 16'h0000, 1'b1);
        run_seq(2'd0, 16'h0000, 0, 0);
        fault_en = 1'b0;
        chk("fault_err_hold", int'(err_a[0]), 1);
        chk("fault_ram_intact", int'(ram0[7]), 32'h007F);

        // Restart from DONE with err set, with stray starts in WRITE and READ
        push_all(2'd1, 16'h0000, 1'b0);
        run_seq(2'd1, 16'h0000, 5, 20);

        // Asynchronous reset in cycle 10 of WRITE
        push_writes(2'd2, 16'h3C3C);
        launch(2'd2, 16'h3C3C);
        repeat (9) @(negedge clk_g);
        #2 rst_n = 1'b0;
        wq.delete();
        #1;
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_ena", int'(ena_a), 0);
        chk("arst_wea", int'(wea_a), 0);
        chk("arst_addr", int'(addr_a[0]), 0);
        chk("arst_dina", int'(dina_a[0]), 0);
        chk("arst_done", int'(done_a), 0);
        repeat (2) @(negedge clk_g);
        rst_n = 1'b1;
        push_all(2'd2, 16'h1234, 1'b0);
        run_seq(2'd2, 16'h1234, 0, 0);
        chk_ram(2'd2, 16'h1234);

        repeat (3) @(negedge clk_g);
        chk("wq_drained", wq.size(), 0);
        chk("rq0_drained", rq0.size(), 0);
        chk("rq1_drained", rq1.size(), 0);
        chk("rq2_drained", rq2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
